vga_timing_gen_p: RTL
=====================

Name: vga_timing_gen_p

Overview:
- Parametrised, next-generation VGA timing core for the display path.
- Generates hsync, vsync and data-enable with configurable sync polarity for any resolution.
- Issues 0-based pixel request coordinates ahead of time so a pixel source with fixed pipeline latency DATA_LAT lines up exactly with the syncs.
- Adds frame/line strobes, a frame counter, and a frame-aligned run/stop control.

Parameters:
H_DISP, 1024, active pixels per line
H_FRONT, 24, horizontal front porch (pixels)
H_SYNC, 136, hsync width (pixels)
H_BACK, 160, horizontal back porch (pixels)
V_DISP, 768, active lines per frame
V_FRONT, 3, vertical front porch (lines)
V_SYNC, 6, vsync width (lines)
V_BACK, 29, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
COLOR_W, 12, RGB width
X_W, 11, hcnt/req_x width; must hold H_TOTAL-1
Y_W, 10, vcnt/req_y width; must hold V_TOTAL-1
DATA_LAT, 1, cycles from request to pix_data valid, 0..7
FCNT_W, 8, frame counter width

Ports:
clk_vga  in  1  pixel clock
rst  in  1  synchronous reset, active-high
en  in  1  run request; sampled every cycle
pix_data  in  COLOR_W  pixel for the request issued DATA_LAT cycles earlier
req_valid  out  1  request coordinates are in the active area
req_x  out  X_W  requested column, 0-based
req_y  out  Y_W  requested line, 0-based
vga_rgb  out  COLOR_W  colour output, 0 when blanked
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_de  out  1  data enable, aligned with vga_rgb
line_start  out  1  one-cycle pulse, aligned with vga_de, on pixel (0,y)
frame_start  out  1  one-cycle pulse, aligned with vga_de, on pixel (0,0)
frame_cnt  out  FCNT_W  completed-start count, wraps modulo 2^FCNT_W
running  out  1  counters advancing (RUN or DRAIN)

Behaviour:
- H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- Region order within a line and within a frame: display, front, sync, back.
- Counters:
  - hcnt counts 0..H_TOTAL-1 and wraps to 0.
  - vcnt increments only when hcnt wraps; vcnt wraps to 0 after V_TOTAL-1.
- FSM states IDLE, RUN, DRAIN:
  - IDLE: counters held at (0,0). Goes to RUN when en=1; counting starts on the next edge, first frame begins at (0,0).
  - RUN: goes to DRAIN when en=0.
  - DRAIN: the current frame finishes. If en returns to 1, go back to RUN with no glitch. When hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1, go to IDLE with counters at (0,0).
- Stage 0 signals are combinational from the counters, qualified by state != IDLE:
  - req_valid = hcnt<H_DISP && vcnt<V_DISP.
  - req_x = hcnt and req_y = vcnt when req_valid, else 0.
  - hs0 is active for H_DISP+H_FRONT <= hcnt < H_DISP+H_FRONT+H_SYNC.
  - vs0 is active for V_DISP+V_FRONT <= vcnt < V_DISP+V_FRONT+V_SYNC; it switches only on line boundaries.
- Alignment:
  - Stage 0 de/hs/vs/line/frame flags pass through a DATA_LAT-deep shift register, followed by one output register.
  - Outputs for coordinate (x,y) requested at cycle t are visible at t+DATA_LAT+1.
  - vga_rgb <= delayed_de ? pix_data : 0, so pix_data is sampled only on the cycle its delayed_de is 1.
  - When DATA_LAT=0, pix_data is treated as combinational from req_x/req_y.
- Polarity: vga_hs = HS_POL when the delayed hs is active, else ~HS_POL; vga_vs likewise with VS_POL.
- frame_cnt increments in the same cycle frame_start is asserted.
- IDLE output levels: syncs at their inactive levels, de=0, rgb=0, strobes=0. The delay line keeps shifting, so in-flight pixels drain normally after a stop.
- Reset, including mid-frame:
  - Within one edge: state IDLE, counters 0, delay line cleared, vga_rgb=0, vga_de=0, vga_hs=~HS_POL, vga_vs=~VS_POL, strobes 0, frame_cnt=0, running=0, req_valid=0.
  - rst has priority over en.
- Simultaneous en=0 on the final pixel of a frame in RUN: go directly to IDLE; no extra frame is generated.

Test Plan:
1. Small params H 8/2/2/2, V 4/1/1/1, DATA_LAT=2, en=1 after reset -> each line lasts 14 cycles and each frame 98 cycles; vga_hs low at hcnt 10-11 (+3 delay); vga_vs low on line 5 only; 32 vga_de cycles per frame; frame_start exactly once per 98 cycles.
2. Pixel source returning {req_y,req_x} after exactly DATA_LAT cycles (sweep DATA_LAT 0,1,3) -> vga_rgb equals {y,x} on every vga_de cycle and 0 elsewhere; the first pixel of frame 0 appears exactly DATA_LAT+1 cycles after counting starts.
3. en dropped mid-frame (line 2) -> frame completes; running falls at the (0,0) wrap; frame_cnt stops incrementing; outputs go idle after DATA_LAT+1 cycles.
4. en dropped then re-raised within the same frame -> no gap in timing; vga_hs/vga_vs periods unchanged.
5. rst pulsed mid-active-line -> next cycle all outputs at their reset values and frame_cnt=0; restart yields frame_start after DATA_LAT+1 cycles.
6. HS_POL=1, VS_POL=1 with the default 1024x768 timing -> vga_hs high for 136 of every 1344 cycles; vga_vs high for 6×1344 cycles per 806-line frame; both low at reset.

Source files
------------

// File: rtl/vga_timing_gen_p_if.sv
// vga_timing_gen_p_if: pixel request/return channel plus VGA output bundle of the timing core
interface vga_timing_gen_p_if #(
    parameter int COLOR_W = 12,
    parameter int X_W     = 11,
    parameter int Y_W     = 10,
    parameter int FCNT_W  = 8
);
    logic               req_valid;
    logic [X_W-1:0]     req_x;
    logic [Y_W-1:0]     req_y;
    logic [COLOR_W-1:0] pix_data;
    logic [COLOR_W-1:0] vga_rgb;
    logic               vga_hs;
    logic               vga_vs;
    logic               vga_de;
    logic               line_start;
    logic               frame_start;
    logic [FCNT_W-1:0]  frame_cnt;
    logic               running;

    modport master (
        output req_valid, req_x, req_y, vga_rgb, vga_hs, vga_vs, vga_de,
               line_start, frame_start, frame_cnt, running,
        input  pix_data
    );

    modport slave (
        input  req_valid, req_x, req_y, vga_rgb, vga_hs, vga_vs, vga_de,
               line_start, frame_start, frame_cnt, running,
        output pix_data
    );
endinterface

// File: rtl/vga_timing_gen_p.sv
// vga_timing_gen_p: parametrised VGA timing core with early pixel requests and frame-aligned run/stop
module vga_timing_gen_p #(
    parameter int H_DISP   = 1024,
    parameter int H_FRONT  = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BACK   = 160,
    parameter int V_DISP   = 768,
    parameter int V_FRONT  = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BACK   = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COLOR_W  = 12,
    parameter int X_W      = 11,
    parameter int Y_W      = 10,
    parameter int DATA_LAT = 1,
    parameter int FCNT_W   = 8
) (
    input  logic               clk_vga,
    input  logic               rst,
    input  logic               en,
    vga_timing_gen_p_if.master bus
);
    localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
    localparam logic [X_W-1:0] H_DE_END = X_W'(H_DISP);
    localparam logic [X_W-1:0] H_HS_BEG = X_W'(H_DISP + H_FRONT);
    localparam logic [X_W-1:0] H_HS_END = X_W'(H_DISP + H_FRONT + H_SYNC);
    localparam logic [X_W-1:0] H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_DE_END = Y_W'(V_DISP);
    localparam logic [Y_W-1:0] V_VS_BEG = Y_W'(V_DISP + V_FRONT);
    localparam logic [Y_W-1:0] V_VS_END = Y_W'(V_DISP + V_FRONT + V_SYNC);
    localparam logic [Y_W-1:0] V_LAST   = Y_W'(V_TOTAL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             r_state;
    logic               r_running;
    logic [X_W-1:0]     r_hcnt;
    logic [Y_W-1:0]     r_vcnt;
    logic [COLOR_W-1:0] r_rgb;
    logic               r_de, r_hs, r_vs, r_ls, r_fs;
    logic [FCNT_W-1:0]  r_fcnt;
    logic               w_last, w_h_last, w_de0, w_hs0, w_vs0, w_x0;
    logic [4:0]         w_s0, w_dly;

    assign w_h_last = r_hcnt == H_LAST;
    assign w_last   = w_h_last && r_vcnt == V_LAST;
    assign w_de0    = r_running && r_hcnt < H_DE_END && r_vcnt < V_DE_END;
    assign w_hs0    = r_running && r_hcnt >= H_HS_BEG && r_hcnt < H_HS_END;
    assign w_vs0    = r_running && r_vcnt >= V_VS_BEG && r_vcnt < V_VS_END;
    assign w_x0     = w_de0 && r_hcnt == '0;
    // Stage-0 flag bundle: {de, hs, vs, line_start, frame_start}
    assign w_s0     = {w_de0, w_hs0, w_vs0, w_x0, w_x0 && r_vcnt == '0};

    assign bus.req_valid   = w_de0;
    assign bus.req_x       = w_de0 ? r_hcnt : '0;
    assign bus.req_y       = w_de0 ? r_vcnt : '0;
    assign bus.vga_rgb     = r_rgb;
    assign bus.vga_de      = r_de;
    assign bus.vga_hs      = r_hs;
    assign bus.vga_vs      = r_vs;
    assign bus.line_start  = r_ls;
    assign bus.frame_start = r_fs;
    assign bus.frame_cnt   = r_fcnt;
    assign bus.running     = r_running;

    // Run/stop FSM and raster counters; a stop request only lands on the last pixel of a frame
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
        end else begin
            if (r_running) begin
                r_hcnt <= w_h_last ? '0 : r_hcnt + 1'b1;
                if (w_h_last)
                    r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_state   <= en ? RUN : IDLE;
                    r_running <= en;
                end
                default: begin
                    if (!en && w_last) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end else begin
                        r_state <= en ? RUN : DRAIN;
                    end
                end
            endcase
        end
    end

    generate
        if (DATA_LAT == 0) begin : g_nodly
            assign w_dly = w_s0;
        end else begin : g_dly
            logic [4:0] r_sr [DATA_LAT];
            // Flag delay line matching the pixel source latency; keeps shifting while idle
            always_ff @(posedge clk_vga) begin
                if (rst) begin
                    for (int i = 0; i < DATA_LAT; i++) r_sr[i] <= '0;
                end else begin
                    r_sr[0] <= w_s0;
                    for (int i = 1; i < DATA_LAT; i++) r_sr[i] <= r_sr[i-1];
                end
            end
            assign w_dly = r_sr[DATA_LAT-1];
        end
    endgenerate

    // Output register: applies sync polarity and captures pixel data only while the delayed DE is high
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_rgb  <= '0;
            r_de   <= 1'b0;
            r_hs   <= ~HS_POL;
            r_vs   <= ~VS_POL;
            r_ls   <= 1'b0;
            r_fs   <= 1'b0;
            r_fcnt <= '0;
        end else begin
            r_de   <= w_dly[4];
            r_rgb  <= w_dly[4] ? bus.pix_data : '0;
            r_hs   <= w_dly[3] ? HS_POL : ~HS_POL;
            r_vs   <= w_dly[2] ? VS_POL : ~VS_POL;
            r_ls   <= w_dly[1];
            r_fs   <= w_dly[0];
            r_fcnt <= r_fcnt + FCNT_W'(w_dly[0]);
        end
    end
endmodule
